// File: rtl/pwm_timebase_ctrl_if.sv
// Bundle between the timer register file / prescaler side and the
// time-base controller. The controller connects through the slave modport;
// the register file (or a bench standing in for it) uses the master modport.
interface pwm_timebase_ctrl_if #(
    parameter int PSC_WIDTH = 16,
    parameter int ARR_WIDTH = 16,
    parameter int RCR_WIDTH = 8
);
    // register-file configuration and strobes
    logic                 cfg_cen_i;
    logic                 cfg_opm_i;
    logic                 cfg_arpe_i;
    logic [PSC_WIDTH-1:0] cfg_psc_i;
    logic [ARR_WIDTH-1:0] cfg_arr_i;
    logic [RCR_WIDTH-1:0] cfg_rcr_i;
    logic                 sw_ug_i;
    logic                 uif_clr_i;
    // prescaler clock-enable feedback
    logic                 ck_cnt_i;
    // controller outputs
    logic                 psc_cen_o;
    logic [PSC_WIDTH-1:0] psc_preload_o;
    logic [ARR_WIDTH-1:0] cnt_o;
    logic [ARR_WIDTH-1:0] arr_active_o;
    logic                 uev_o;
    logic                 uif_o;
    logic                 cen_clr_o;

    modport master (
        output cfg_cen_i, cfg_opm_i, cfg_arpe_i, cfg_psc_i, cfg_arr_i, cfg_rcr_i,
        output sw_ug_i, uif_clr_i, ck_cnt_i,
        input  psc_cen_o, psc_preload_o, cnt_o, arr_active_o, uev_o, uif_o, cen_clr_o
    );

    modport slave (
        input  cfg_cen_i, cfg_opm_i, cfg_arpe_i, cfg_psc_i, cfg_arr_i, cfg_rcr_i,
        input  sw_ug_i, uif_clr_i, ck_cnt_i,
        output psc_cen_o, psc_preload_o, cnt_o, arr_active_o, uev_o, uif_o, cen_clr_o
    );
endinterface

// File: rtl/pwm_timebase_ctrl.sv
// Time-base controller: sequences the prescaler (enable / preload), counts
// its clock-enable pulses into an auto-reload up-counter with a repetition
// counter, and raises update events that commit the shadowed PSC/ARR/RCR.
// Supports one-pulse mode and software update generation. Every output is
// a flop; next values are computed in one combinational block.
module pwm_timebase_ctrl #(
    parameter int PSC_WIDTH = 16,
    parameter int ARR_WIDTH = 16,
    parameter int RCR_WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    pwm_timebase_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_STOP = 2'd3
    } state_e;

    state_e               state_q,       state_d;
    logic                 psc_cen_q,     psc_cen_d;
    logic [PSC_WIDTH-1:0] psc_preload_q, psc_preload_d;
    logic [ARR_WIDTH-1:0] cnt_q,         cnt_d;
    logic [ARR_WIDTH-1:0] arr_active_q,  arr_active_d;
    logic [RCR_WIDTH-1:0] rep_cnt_q,     rep_cnt_d;
    logic                 uev_q,         uev_d;
    logic                 uif_q,         uif_d;
    logic                 cen_clr_q,     cen_clr_d;
    // High for the single cycle after a software update in RUN: the
    // prescaler is held off to restart it and counter pulses are dropped.
    logic                 blank_q,       blank_d;
    logic                 ug_evt;

    // Next-state and next-output computation for the whole time base.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rep_cnt_d     = rep_cnt_q;
        psc_preload_d = psc_preload_q;
        // Without ARR preload the programmed value is followed every cycle.
        arr_active_d  = bus.cfg_arpe_i ? arr_active_q : bus.cfg_arr_i;
        uev_d         = 1'b0;
        cen_clr_d     = 1'b0;
        blank_d       = 1'b0;
        ug_evt        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.sw_ug_i) begin
                    ug_evt = 1'b1;
                end
                if (bus.cfg_cen_i) begin
                    state_d = ST_ARM;
                end
            end

            ST_ARM: begin
                // Prescaler is held disabled this cycle, which clears it,
                // while the shadows pick up the programmed values.
                psc_preload_d = bus.cfg_psc_i;
                arr_active_d  = bus.cfg_arr_i;
                rep_cnt_d     = bus.cfg_rcr_i;
                if (bus.sw_ug_i) begin
                    ug_evt = 1'b1;
                end
                state_d = bus.cfg_cen_i ? ST_RUN : ST_IDLE;
            end

            ST_RUN: begin
                if (!bus.cfg_cen_i) begin
                    // Disable outranks a same-cycle update request.
                    state_d = ST_IDLE;
                end else if (bus.sw_ug_i) begin
                    ug_evt  = 1'b1;
                    blank_d = 1'b1;
                end else if (!blank_q && bus.ck_cnt_i) begin
                    // >= rather than == so a live ARR lowered below the
                    // count still wraps on the next pulse.
                    if (cnt_q < arr_active_q) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        cnt_d = '0;
                        if (rep_cnt_q != '0) begin
                            rep_cnt_d = rep_cnt_q - 1'b1;
                        end else begin
                            uev_d         = 1'b1;
                            rep_cnt_d     = bus.cfg_rcr_i;
                            psc_preload_d = bus.cfg_psc_i;
                            arr_active_d  = bus.cfg_arr_i;
                            if (bus.cfg_opm_i) begin
                                cen_clr_d = 1'b1;
                                state_d   = ST_STOP;
                            end
                        end
                    end
                end
            end

            ST_STOP: begin
                // Parked after a one-pulse period until software drops CEN.
                cnt_d = '0;
                if (!bus.cfg_cen_i) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Software update: restart the period and reload every shadow.
        if (ug_evt) begin
            cnt_d         = '0;
            rep_cnt_d     = bus.cfg_rcr_i;
            psc_preload_d = bus.cfg_psc_i;
            arr_active_d  = bus.cfg_arr_i;
            uev_d         = 1'b1;
        end

        // A new update event wins over a simultaneous flag clear.
        if (uev_d) begin
            uif_d = 1'b1;
        end else if (bus.uif_clr_i) begin
            uif_d = 1'b0;
        end else begin
            uif_d = uif_q;
        end

        psc_cen_d = (state_d == ST_RUN) && !blank_d;
    end

    // State and output registers; reset returns everything to zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            psc_cen_q     <= 1'b0;
            psc_preload_q <= '0;
            cnt_q         <= '0;
            arr_active_q  <= '0;
            rep_cnt_q     <= '0;
            uev_q         <= 1'b0;
            uif_q         <= 1'b0;
            cen_clr_q     <= 1'b0;
            blank_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            psc_cen_q     <= psc_cen_d;
            psc_preload_q <= psc_preload_d;
            cnt_q         <= cnt_d;
            arr_active_q  <= arr_active_d;
            rep_cnt_q     <= rep_cnt_d;
            uev_q         <= uev_d;
            uif_q         <= uif_d;
            cen_clr_q     <= cen_clr_d;
            blank_q       <= blank_d;
        end
    end

    assign bus.psc_cen_o     = psc_cen_q;
    assign bus.psc_preload_o = psc_preload_q;
    assign bus.cnt_o         = cnt_q;
    assign bus.arr_active_o  = arr_active_q;
    assign bus.uev_o         = uev_q;
    assign bus.uif_o         = uif_q;
    assign bus.cen_clr_o     = cen_clr_q;

endmodule

// File: doc/pwm_timebase_ctrl.md
Name: pwm_timebase_ctrl

Overview:
Time-base controller that sequences the pwm_prescaler. It drives the prescaler enable and preload, and counts prescaler clock-enable pulses into an auto-reload up-counter with a repetition counter. It generates update events (UEV) that commit shadowed PSC/ARR/RCR values, and supports one-pulse mode and software update generation. It sits between the timer register file and the prescaler/compare channels.

Parameters:
PSC_WIDTH, 16, prescaler preload width
ARR_WIDTH, 16, auto-reload / counter width
RCR_WIDTH, 8, repetition counter width

Ports:
clk_i  in  1  timer clock, shared with pwm_prescaler clk_psc_i
rst_i  in  1  synchronous reset, active-high
cfg_cen_i  in  1  software counter enable (level)
cfg_opm_i  in  1  one-pulse mode
cfg_arpe_i  in  1  1: ARR shadowed until UEV; 0: ARR taken live
cfg_psc_i  in  PSC_WIDTH  programmed prescaler value
cfg_arr_i  in  ARR_WIDTH  programmed auto-reload value
cfg_rcr_i  in  RCR_WIDTH  programmed repetition count
sw_ug_i  in  1  software update-generation pulse (1 cycle)
uif_clr_i  in  1  clear update interrupt flag
ck_cnt_i  in  1  clock-enable pulse from prescaler ck_cnt_o
psc_cen_o  out  1  to prescaler cen_i
psc_preload_o  out  PSC_WIDTH  to prescaler psc_preload_i (shadowed)
cnt_o  out  ARR_WIDTH  current counter value
arr_active_o  out  ARR_WIDTH  ARR value in effect
uev_o  out  1  update event pulse, 1 cycle
uif_o  out  1  sticky update flag
cen_clr_o  out  1  1-cycle request to register file to clear CEN (OPM end)

Behaviour:
- Reset (rst_i=1 at posedge), highest priority, valid from any state: state=IDLE. All outputs 0, including psc_preload_o, arr_active_o, cnt_o, uif_o. Internal rep_cnt=0.
- All outputs registered. uev_o/cen_clr_o asserted the cycle after the triggering sample.
- States: IDLE, ARM, RUN, STOP.
- IDLE: psc_cen_o=0, cnt_o holds. If cfg_cen_i=1 -> ARM.
- ARM (1 cycle): psc_cen_o=0, which clears the prescaler counter. Load psc_preload_o<=cfg_psc_i, arr_active_o<=cfg_arr_i, rep_cnt<=cfg_rcr_i. cnt_o holds (not cleared). Next state RUN; if cfg_cen_i=0, go to IDLE instead.
- RUN: psc_cen_o=1. On ck_cnt_i=1:
  - if cnt_o < arr_active_o: cnt_o+1.
  - if cnt_o >= arr_active_o: cnt_o<=0 (overflow).
    - Overflow with rep_cnt!=0: rep_cnt-1, no UEV.
    - Overflow with rep_cnt==0: UEV. uev_o=1, uif_o<=1, rep_cnt<=cfg_rcr_i, psc_preload_o<=cfg_psc_i, arr_active_o<=cfg_arr_i. If cfg_opm_i=1: cen_clr_o=1, next state STOP.
  - cfg_cen_i=0 in RUN -> IDLE next cycle, psc_cen_o=0, cnt_o holds.
- STOP: psc_cen_o=0, cnt_o=0. Go to IDLE when cfg_cen_i=0. cen_clr_o pulses once only.
- cfg_arpe_i=0: arr_active_o<=cfg_arr_i every cycle in every state except reset. The comparison uses the registered value. If cfg_arr_i is lowered below cnt_o, the >= compare forces overflow on the next ck_cnt_i.
- ARR=0: every ck_cnt_i is an overflow; cnt_o stays 0.
- sw_ug_i, in IDLE/ARM/RUN:
  - cnt_o<=0, rep_cnt<=cfg_rcr_i, all shadows reload, uev_o=1, uif_o<=1.
  - In RUN: psc_cen_o=0 for exactly the next cycle (prescaler restart), then 1. ck_cnt_i during that cycle is ignored.
  - No OPM stop from a UG. Ignored in STOP.
- Priority within a cycle: rst_i > cfg_cen_i=0 (RUN exit) > sw_ug_i > ck_cnt_i.
- uif_o: set on any UEV, cleared by uif_clr_i. Set wins over a simultaneous clear.
- Widths: cnt_o wraps only through the compare; never increments past arr_active_o. rep_cnt decrement never underflows.

Test Plan:
- Reset/idle: rst_i=1 for 2 cycles -> all outputs 0. cfg_cen_i=0 with ck_cnt_i pulses -> cnt_o stays 0, psc_cen_o=0.
- Basic count: PSC=0 (ck_cnt_i every cycle via prescaler), ARR=4, RCR=0, cfg_cen_i=1 -> ARM 1 cycle. Then cnt_o 0,1,2,3,4,0 … with uev_o every 5th ck_cnt_i. uif_o=1 until uif_clr_i.
- Repetition: ARR=2, RCR=2 -> uev_o once per 3 overflows (every 9 ck_cnt_i). Change cfg_rcr_i to 0 mid-period -> new value takes effect only after the next UEV.
- Shadowing: cfg_arpe_i=1, ARR=9 running, write cfg_arr_i=3 at cnt_o=5 -> counts to 9 first, then period 4. Repeat with cfg_arpe_i=0 and write 3 at cnt_o=5 -> overflow on next ck_cnt_i.
- One-pulse: cfg_opm_i=1, ARR=3, RCR=1 -> 8 ck_cnt_i, one uev_o, cen_clr_o single pulse, STOP with psc_cen_o=0. Drop cfg_cen_i -> IDLE.
- UG and collisions:
  - sw_ug_i at cnt_o=6 -> cnt_o=0, uev_o=1, psc_cen_o low exactly 1 cycle.
  - sw_ug_i coincident with ck_cnt_i -> single UEV, cnt_o=0.
  - uif_clr_i coincident with UEV -> uif_o=1.
  - rst_i mid-RUN -> IDLE, all zeros next cycle.
